// File: rtl/bundle_ctrl_pkg.sv
// Shared encodings, FSM states and the per-slot decode record for bundle_ctrl.
// The optional memory watchdog is enabled by defining BUNDLE_CTRL_MEM_TIMEOUT_EN.
package bundle_ctrl_pkg;

    localparam logic [4:0] OP_NOP     = 5'b00000;
    localparam logic [4:0] OP_ALU_IMM = 5'b00101;
    localparam logic [4:0] OP_ALU_REG = 5'b01000;
    localparam logic [4:0] OP_LOAD    = 5'b01010;
    localparam logic [4:0] OP_STORE   = 5'b01011;
    localparam logic [4:0] OP_BRANCH  = 5'b11011;
    localparam logic [4:0] OP_JUMP    = 5'b11110;

    localparam logic [2:0] SUB_LOGIC = 3'b010;
    localparam logic [2:0] SUB_CARRY = 3'b011;
    localparam logic [2:0] SUB_ARITH = 3'b100;

    localparam logic [1:0] ALU_OP_ARITH = 2'b00;
    localparam logic [1:0] ALU_OP_IMM   = 2'b01;
    localparam logic [1:0] ALU_OP_LOGIC = 2'b10;
    localparam logic [1:0] ALU_OP_CARRY = 2'b11;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_MEM   = ST_MEM,
        S_WB    = ST_WB
    } state_e;

    // flags are ordered {z, n, c, v}
    typedef struct packed {
        logic       reg_write;
        logic [3:0] flags;
        logic [1:0] alu_op;
        logic       src_a;
        logic       src_b;
        logic       is_load;
        logic       is_store;
        logic       is_jump;
        logic       is_branch;
        logic       illegal;
    } slot_dec_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bundle_ctrl_slot_decode.sv
// Combinational opcode/subfunction decode for one bundle slot.
// Illegal encodings decode as a nop with only the illegal bit set.
module slot_decode
    import bundle_ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    input  logic [2:0] subfn_i,
    output slot_dec_t  dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (opcode_i)
            OP_ALU_REG: begin
                unique case (subfn_i)
                    SUB_ARITH: begin
                        dec_o.reg_write = 1'b1;
                        dec_o.flags     = 4'b1111;
                        dec_o.alu_op    = ALU_OP_ARITH;
                    end
                    SUB_CARRY: begin
                        dec_o.reg_write = 1'b1;
                        dec_o.flags     = 4'b1110;
                        dec_o.alu_op    = ALU_OP_CARRY;
                    end
                    SUB_LOGIC: begin
                        dec_o.reg_write = 1'b1;
                        dec_o.flags     = 4'b1100;
                        dec_o.alu_op    = ALU_OP_LOGIC;
                    end
                    default: dec_o.illegal = 1'b1;
                endcase
            end
            OP_ALU_IMM: begin
                dec_o.reg_write = 1'b1;
                dec_o.flags     = 4'b1111;
                dec_o.alu_op    = ALU_OP_IMM;
                dec_o.src_a     = 1'b1;
                dec_o.src_b     = 1'b1;
            end
            OP_LOAD:   dec_o.is_load   = 1'b1;
            OP_STORE:  dec_o.is_store  = 1'b1;
            OP_JUMP:   dec_o.is_jump   = 1'b1;
            OP_BRANCH: dec_o.is_branch = 1'b1;
            OP_NOP:    ;
            default:   dec_o.illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/bundle_ctrl.sv
// Sequenced multi-slot bundle controller with registered control outputs and a
// serialised memory handshake. Define BUNDLE_CTRL_MEM_TIMEOUT_EN for the watchdog.
module bundle_ctrl
    import bundle_ctrl_pkg::*;
#(
    parameter int unsigned SLOTS   = 2,
    parameter int unsigned SLOT_W  = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SLOTS*SLOT_W-1:0]   ir,
    input  logic                      ir_valid,
    output logic                      ir_ready,
    output logic [SLOTS-1:0]          reg_write,
    output logic [4*SLOTS-1:0]        flag_write,
    output logic [2*SLOTS-1:0]        alu_op,
    output logic [SLOTS-1:0]          alu_src_a,
    output logic [SLOTS-1:0]          alu_src_b,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [idx_w(SLOTS)-1:0]   mem_slot,
    input  logic                      mem_ack,
    output logic                      pc_write,
    output logic                      branch,
    output logic [1:0]                pc_src,
    output logic                      illegal,
    output logic                      mem_err
);

    localparam int unsigned MS_W = idx_w(SLOTS);

    slot_dec_t dec [SLOTS];

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        slot_decode u_dec (
            .opcode_i (ir[k*SLOT_W +: 5]),
            .subfn_i  (ir[k*SLOT_W+5 +: 3]),
            .dec_o    (dec[k])
        );
    end

    logic unused_ir;
    assign unused_ir = ^ir;

    // ISSUE outputs are computed from the incoming bundle so they can be
    // registered on the very edge that accepts it.
    logic [SLOTS-1:0]   iss_rw, iss_sa, iss_sb, iss_load, iss_mem;
    logic [4*SLOTS-1:0] iss_fw;
    logic [2*SLOTS-1:0] iss_op;
    logic               iss_ill, iss_cf_seen, iss_br;
    logic [1:0]         iss_pc_src;

    always_comb begin
        iss_rw      = '0;
        iss_sa      = '0;
        iss_sb      = '0;
        iss_load    = '0;
        iss_mem     = '0;
        iss_fw      = '0;
        iss_op      = '0;
        iss_ill     = 1'b0;
        iss_cf_seen = 1'b0;
        iss_br      = 1'b0;
        iss_pc_src  = PC_SRC_SEQ;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            iss_rw[k]         = dec[k].reg_write;
            iss_fw[4*k +: 4]  = dec[k].flags;
            iss_op[2*k +: 2]  = dec[k].alu_op;
            iss_sa[k]         = dec[k].src_a;
            iss_sb[k]         = dec[k].src_b;
            iss_load[k]       = dec[k].is_load;
            iss_mem[k]        = dec[k].is_load | dec[k].is_store;
            if (dec[k].illegal) iss_ill = 1'b1;
            if (dec[k].is_jump || dec[k].is_branch) begin
                if (iss_cf_seen) begin
                    iss_ill = 1'b1;
                end else begin
                    iss_cf_seen = 1'b1;
                    iss_br      = dec[k].is_branch;
                    iss_pc_src  = dec[k].is_branch ? PC_SRC_BRANCH : PC_SRC_JUMP;
                end
            end
        end
    end

    function automatic logic [MS_W-1:0] lowest(input logic [SLOTS-1:0] m);
        logic [MS_W-1:0] res;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (m[i] && !found) begin
                res   = MS_W'(i);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    state_e             state_q, state_d;
    logic [SLOTS-1:0]   pend_q, pend_d, load_q, load_d;
    logic [MS_W-1:0]    cur_q, cur_d;
    logic [1:0]         cf_src_q, cf_src_d;
    logic               cf_br_q, cf_br_d;

    logic [SLOTS-1:0]   rw_q, rw_d, sa_q, sa_d, sb_q, sb_d;
    logic [4*SLOTS-1:0] fw_q, fw_d;
    logic [2*SLOTS-1:0] op_q, op_d;
    logic               mrd_q, mrd_d, mwr_q, mwr_d;
    logic [MS_W-1:0]    mslot_q, mslot_d;
    logic               pcw_q, pcw_d, br_q, br_d, ill_q, ill_d;
    logic [1:0]         pcs_q, pcs_d;
    logic               rdy_q, rdy_d;
    logic               merr_d;

`ifdef BUNDLE_CTRL_MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = idx_w(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              merr_q;
`endif

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        load_d   = load_q;
        cur_d    = cur_q;
        cf_src_d = cf_src_q;
        cf_br_d  = cf_br_q;
        rw_d     = '0;
        fw_d     = '0;
        op_d     = '0;
        sa_d     = '0;
        sb_d     = '0;
        mrd_d    = 1'b0;
        mwr_d    = 1'b0;
        mslot_d  = '0;
        pcw_d    = 1'b0;
        br_d     = 1'b0;
        pcs_d    = PC_SRC_SEQ;
        ill_d    = 1'b0;
        merr_d   = 1'b0;
`ifdef BUNDLE_CTRL_MEM_TIMEOUT_EN
        wait_d   = wait_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ir_valid && rdy_q) begin
                    state_d  = S_ISSUE;
                    pend_d   = iss_mem;
                    load_d   = iss_load;
                    cf_src_d = iss_pc_src;
                    cf_br_d  = iss_br;
                    rw_d     = iss_rw;
                    fw_d     = iss_fw;
                    op_d     = iss_op;
                    sa_d     = iss_sa;
                    sb_d     = iss_sb;
                    ill_d    = iss_ill;
                    if (iss_mem == '0) begin
                        pcw_d = 1'b1;
                        pcs_d = iss_pc_src;
                        br_d  = iss_br;
                    end
                end
            end
            S_ISSUE, S_WB: begin
                if (pend_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MEM;
                    cur_d   = lowest(pend_q);
`ifdef BUNDLE_CTRL_MEM_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d        = S_WB;
                    pend_d[cur_q]  = 1'b0;
                    if (load_q[cur_q]) begin
                        rw_d[cur_q]          = 1'b1;
                        fw_d[4*cur_q +: 4]   = 4'b1100;
                    end
                    if (pend_d == '0) begin
                        pcw_d = 1'b1;
                        pcs_d = cf_src_q;
                        br_d  = cf_br_q;
                    end
                end
`ifdef BUNDLE_CTRL_MEM_TIMEOUT_EN
                else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    merr_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        // strobes are a function of the next state so they hold for every MEM cycle
        if (state_d == S_MEM) begin
            mrd_d   = load_q[cur_d];
            mwr_d   = ~load_q[cur_d];
            mslot_d = cur_d;
        end
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            load_q   <= '0;
            cur_q    <= '0;
            cf_src_q <= '0;
            cf_br_q  <= 1'b0;
            rw_q     <= '0;
            fw_q     <= '0;
            op_q     <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            mslot_q  <= '0;
            pcw_q    <= 1'b0;
            br_q     <= 1'b0;
            pcs_q    <= '0;
            ill_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            load_q   <= load_d;
            cur_q    <= cur_d;
            cf_src_q <= cf_src_d;
            cf_br_q  <= cf_br_d;
            rw_q     <= rw_d;
            fw_q     <= fw_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            mslot_q  <= mslot_d;
            pcw_q    <= pcw_d;
            br_q     <= br_d;
            pcs_q    <= pcs_d;
            ill_q    <= ill_d;
            rdy_q    <= rdy_d;
        end
    end

`ifdef BUNDLE_CTRL_MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
            merr_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
            merr_q <= merr_d;
        end
    end
    assign mem_err = merr_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    logic unused_merr;
    assign unused_merr = merr_d;
    assign mem_err     = 1'b0;
`endif

    assign ir_ready   = rdy_q;
    assign reg_write  = rw_q;
    assign flag_write = fw_q;
    assign alu_op     = op_q;
    assign alu_src_a  = sa_q;
    assign alu_src_b  = sb_q;
    assign mem_read   = mrd_q;
    assign mem_write  = mwr_q;
    assign mem_slot   = mslot_q;
    assign pc_write   = pcw_q;
    assign branch     = br_q;
    assign pc_src     = pcs_q;
    assign illegal    = ill_q;

endmodule

// File: tb/tb_bundle_ctrl.sv
// Directed bench for bundle_ctrl (SLOTS=2, SLOT_W=16, TIMEOUT=8).
// Watchdog steps are selected by BUNDLE_CTRL_MEM_TIMEOUT_EN.
module tb_bundle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir = '0;
    logic        ir_valid = 1'b0;
    logic        mem_ack = 1'b0;
    logic        ir_ready;
    logic [1:0]  reg_write;
    logic [7:0]  flag_write;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_a, alu_src_b;
    logic        mem_read, mem_write;
    logic [0:0]  mem_slot;
    logic        pc_write, branch;
    logic [1:0]  pc_src;
    logic        illegal, mem_err;

    int checks = 0;
    int errors = 0;

    bundle_ctrl #(.SLOTS(2), .SLOT_W(16), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .reg_write  (reg_write),
        .flag_write (flag_write),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_slot   (mem_slot),
        .mem_ack    (mem_ack),
        .pc_write   (pc_write),
        .branch     (branch),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sl(input logic [4:0] op, input logic [2:0] sub);
        return {8'h00, sub, op};
    endfunction

    initial begin
        // reset
        step();
        step();
        check("rst_ready", 32'(ir_ready), 0);
        check("rst_pcw", 32'(pc_write), 0);
        check("rst_rw", 32'(reg_write), 0);
        check("rst_mrd", 32'(mem_read), 0);
        check("rst_ill", 32'(illegal), 0);
        rst = 1'b0;
        step();
        check("post_rst_ready", 32'(ir_ready), 1);

        // ALU reg add in slot0, nop slot1
        ir = {sl(5'b00000, 3'b000), sl(5'b01000, 3'b100)};
        ir_valid = 1'b1;
        step();
        check("alu_rw", 32'(reg_write), 32'h1);
        check("alu_fw", 32'(flag_write), 32'h0F);
        check("alu_op", 32'(alu_op), 32'h0);
        check("alu_pcw", 32'(pc_write), 1);
        check("alu_pcsrc", 32'(pc_src), 0);
        check("alu_ready_low", 32'(ir_ready), 0);
        ir_valid = 1'b0;
        step();
        check("alu_ready_back", 32'(ir_ready), 1);
        check("alu_pcw_pulse", 32'(pc_write), 0);
        check("alu_rw_pulse", 32'(reg_write), 0);

        // ALU imm slot1, carry op slot0
        ir = {sl(5'b00101, 3'b000), sl(5'b01000, 3'b011)};
        ir_valid = 1'b1;
        step();
        check("imm_rw", 32'(reg_write), 32'h3);
        check("imm_fw", 32'(flag_write), 32'hFE);
        check("imm_op", 32'(alu_op), 32'h7);
        check("imm_sa", 32'(alu_src_a), 32'h2);
        check("imm_sb", 32'(alu_src_b), 32'h2);
        check("imm_ill", 32'(illegal), 0);
        ir_valid = 1'b0;
        step();

        // logic op slot1, illegal subfunction slot0
        ir = {sl(5'b01000, 3'b010), sl(5'b01000, 3'b000)};
        ir_valid = 1'b1;
        step();
        check("sub_rw", 32'(reg_write), 32'h2);
        check("sub_fw", 32'(flag_write), 32'hC0);
        check("sub_op", 32'(alu_op), 32'h8);
        check("sub_ill", 32'(illegal), 1);
        check("sub_pcw", 32'(pc_write), 1);
        ir_valid = 1'b0;
        step();
        check("sub_ill_pulse", 32'(illegal), 0);

        // two loads, ack on 4th MEM cycle each
        ir = {sl(5'b01010, 3'b000), sl(5'b01010, 3'b000)};
        ir_valid = 1'b1;
        step();
        check("ld_issue_pcw", 32'(pc_write), 0);
        check("ld_issue_mrd", 32'(mem_read), 0);
        check("ld_issue_ready", 32'(ir_ready), 0);
        ir_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ld0_mrd", 32'(mem_read), 1);
            check("ld0_slot", 32'(mem_slot), 0);
            check("ld0_pcw", 32'(pc_write), 0);
        end
        mem_ack = 1'b1;
        step();
        check("ld0_wb_rw", 32'(reg_write), 32'h1);
        check("ld0_wb_fw", 32'(flag_write), 32'h0C);
        check("ld0_wb_mrd", 32'(mem_read), 0);
        check("ld0_wb_pcw", 32'(pc_write), 0);
        step();
        mem_ack = 1'b0;
        check("ld1_mrd", 32'(mem_read), 1);
        check("ld1_slot", 32'(mem_slot), 1);
        check("ld1_rw", 32'(reg_write), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ld1_mrd_hold", 32'(mem_read), 1);
            check("ld1_slot_hold", 32'(mem_slot), 1);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("ld1_wb_rw", 32'(reg_write), 32'h2);
        check("ld1_wb_fw", 32'(flag_write), 32'hC0);
        check("ld1_wb_pcw", 32'(pc_write), 1);
        check("ld1_wb_pcsrc", 32'(pc_src), 0);
        step();
        check("ld_done_ready", 32'(ir_ready), 1);
        check("ld_done_pcw", 32'(pc_write), 0);

        // branch slot0 and jump slot1
        ir = {sl(5'b11110, 3'b000), sl(5'b11011, 3'b000)};
        ir_valid = 1'b1;
        step();
        check("cf2_pcw", 32'(pc_write), 1);
        check("cf2_pcsrc", 32'(pc_src), 1);
        check("cf2_branch", 32'(branch), 1);
        check("cf2_ill", 32'(illegal), 1);
        ir_valid = 1'b0;
        step();
        check("cf2_pcsrc_idle", 32'(pc_src), 0);
        check("cf2_branch_idle", 32'(branch), 0);

        // jump alone in slot1
        ir = {sl(5'b11110, 3'b000), sl(5'b00000, 3'b000)};
        ir_valid = 1'b1;
        step();
        check("jmp_pcsrc", 32'(pc_src), 2);
        check("jmp_branch", 32'(branch), 0);
        check("jmp_ill", 32'(illegal), 0);
        ir_valid = 1'b0;
        step();

        // illegal opcode in slot0
        ir = {sl(5'b00000, 3'b000), sl(5'b11111, 3'b000)};
        ir_valid = 1'b1;
        step();
        check("ilop_ill", 32'(illegal), 1);
        check("ilop_rw", 32'(reg_write), 0);
        check("ilop_fw", 32'(flag_write), 0);
        check("ilop_pcw", 32'(pc_write), 1);
        check("ilop_pcsrc", 32'(pc_src), 0);
        ir_valid = 1'b0;
        step();
        check("ilop_pulse", 32'(illegal), 0);

        // store in slot1, reset (with ack) in its 2nd MEM cycle
        ir = {sl(5'b01011, 3'b000), sl(5'b00000, 3'b000)};
        ir_valid = 1'b1;
        step();
        ir_valid = 1'b0;
        step();
        check("st_mwr", 32'(mem_write), 1);
        check("st_mrd", 32'(mem_read), 0);
        check("st_slot", 32'(mem_slot), 1);
        step();
        check("st_mwr2", 32'(mem_write), 1);
        rst = 1'b1;
        mem_ack = 1'b1;
        step();
        check("st_rst_mwr", 32'(mem_write), 0);
        check("st_rst_pcw", 32'(pc_write), 0);
        check("st_rst_ready", 32'(ir_ready), 0);
        rst = 1'b0;
        mem_ack = 1'b0;
        step();
        check("st_after_ready", 32'(ir_ready), 1);
        check("st_after_pcw", 32'(pc_write), 0);
        check("st_after_mwr", 32'(mem_write), 0);

        // load with no ack
        ir = {sl(5'b00000, 3'b000), sl(5'b01010, 3'b000)};
        ir_valid = 1'b1;
        step();
        ir_valid = 1'b0;
`ifdef BUNDLE_CTRL_MEM_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            step();
            check("to_mrd", 32'(mem_read), 1);
            check("to_err_low", 32'(mem_err), 0);
        end
        step();
        check("to_err", 32'(mem_err), 1);
        check("to_mrd_drop", 32'(mem_read), 0);
        check("to_pcw", 32'(pc_write), 0);
        check("to_rw", 32'(reg_write), 0);
        check("to_ready", 32'(ir_ready), 1);
        step();
        check("to_err_pulse", 32'(mem_err), 0);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            check("wait_mrd", 32'(mem_read), 1);
            check("wait_err", 32'(mem_err), 0);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("wait_wb_rw", 32'(reg_write), 32'h1);
        check("wait_wb_pcw", 32'(pc_write), 1);
        step();
        check("wait_ready", 32'(ir_ready), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bundle_ctrl.md
# bundle_ctrl

Sequenced control unit for the multi-slot instruction bundle. It generalises the fixed two-slot combinational decoder to `SLOTS` identical slots, each able to carry any opcode. It registers every control output and serialises memory operations over a `mem_req`/`mem_ack` handshake with wait states. It sits between the bundle fetch register and the datapath (register file, ALU, flag register, PC, data memory).

## Interface
- `SLOTS`, default 2: number of slots per bundle (1..8).
- `SLOT_W`, default 16: bit stride between slots; bundle width is `SLOTS*SLOT_W`.
- `TIMEOUT`, default 16: memory watchdog limit in cycles; used only with the configuration macro.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ir` in `SLOTS*SLOT_W`: bundle; slot k opcode `ir[k*SLOT_W +: 5]`, subfunction `ir[k*SLOT_W+5 +: 3]`.
- `ir_valid` in 1 / `ir_ready` out 1: bundle handshake.
- `reg_write` out `SLOTS`: per-slot register-file write pulse.
- `flag_write` out `4*SLOTS`: per-slot {z,n,c,v} write enables.
- `alu_op` out `2*SLOTS`; `alu_src_a`, `alu_src_b` out `SLOTS`.
- `mem_read`, `mem_write` out 1; `mem_slot` out `$clog2(SLOTS)` (min 1); `mem_ack` in 1.
- `pc_write`, `branch` out 1; `pc_src` out 2 (00 seq, 01 branch, 10 jump).
- `illegal` out 1: one-cycle pulse.
- `mem_err` out 1: one-cycle pulse (macro only, else tied 0).

## Operation
- Opcodes per slot:
  - `01000` ALU reg: reg_write, z/n write, src A/B = 0. Subfunction 100 → alu_op 00 with c,v write; 011 → alu_op 11 with c write; 010 → alu_op 10, no c/v write; other subfunctions are illegal.
  - `00101` ALU imm: reg_write, all four flags, src A/B = 1, alu_op 01.
  - `01010` load; `01011` store; `11110` jump; `11011` branch; `00000` nop.
  - Any other opcode is illegal, decoded as nop, and `illegal` pulses in ISSUE.
- FSM states: IDLE, ISSUE, MEM, WB.
  - IDLE: `ir_ready`=1; accept on `ir_valid&&ir_ready`; latch bundle, go to ISSUE.
  - ISSUE: one cycle; drive ALU-slot controls. If no memory slots, also `pc_write` and go to IDLE; else go to MEM with the lowest-numbered memory slot.
  - MEM: hold `mem_read`/`mem_write` and `mem_slot` steady until `mem_ack` is sampled high, then go to WB.
  - WB: one cycle. A load drives `reg_write[slot]` and z/n write; a store drives nothing. Then go to MEM with the next memory slot in ascending order, or, if this was the last, pulse `pc_write` and go to IDLE.
- Control flow:
  - The lowest-numbered jump/branch slot sets `pc_src`/`branch`.
  - A second control-flow slot raises `illegal` and is ignored.
  - `pc_src`/`branch` are valid only while `pc_write`=1; otherwise 0.
- All outputs are 0 outside the cycles named above.
- Reset values: all outputs 0; `ir_ready` 0 during reset, 1 from the first cycle after.

## Timing
- Accept at edge T → ISSUE outputs during T..T+1. An ALU-only bundle retires with `pc_write` in that same cycle.
- Minimum bundle period is 2 cycles; `ir_ready` is low from ISSUE until return to IDLE.
- Each memory op takes 1 MEM cycle plus its wait cycles, then 1 WB cycle. `mem_ack` sampled while not in MEM is ignored.
- `rst` mid-bundle: at that edge, all outputs including `mem_read`/`mem_write` drop to 0, the FSM returns to IDLE, and the bundle is discarded with no `pc_write`.
- `mem_ack` in the same cycle as `rst`: reset wins.

## Configuration
- `BUNDLE_CTRL_MEM_TIMEOUT_EN` defined: a wait counter clears on MEM entry. Reaching `TIMEOUT` cycles without ack drops the memory strobe, pulses `mem_err`, and returns to IDLE without `pc_write` or writeback.
- Undefined: no counter; MEM waits indefinitely; `mem_err`=0.

## Structure
- `bundle_ctrl_pkg`:
  - opcode constants
  - subfunction constants
  - `alu_op` encodings
  - `pc_src` encodings
  - FSM state enum
  - per-slot decode struct {reg_write, flags, alu_op, src_a, src_b, is_load, is_store, is_jump, is_branch, illegal}
- Sub-module `slot_decode`: combinational opcode → decode struct, instantiated `SLOTS` times.

## Test plan
- ALU-only bundle: slot0 `01000`/sub 100, slot1 nop → ISSUE: `reg_write`=01, slot0 flags 1111, `alu_op`=00, `pc_write`=1, `pc_src`=00; `ir_ready`=1 the next cycle.
- Two loads (slot0, slot1), `mem_ack` after 3 wait cycles each:
  - `mem_slot` 0 then 1, `mem_read` held 4 cycles each.
  - WB pulses `reg_write` 01 then 10.
  - `pc_write` only in the final WB; total 1+4+1+4+1 cycles.
- Jump in slot1 and branch in slot0 → `pc_src`=01, `branch`=1, `illegal`=1 in ISSUE.
- Opcode `11111` in slot0 → `illegal` pulse, all slot0 controls 0, `pc_write`=1 with `pc_src`=00.
- `rst` asserted in the 2nd MEM cycle of a store → `mem_write`=0 next cycle, no WB, `ir_ready`=1 after release.
- Macro defined, `TIMEOUT`=8, no ack → `mem_err` pulse after 8 MEM cycles, no `pc_write`, FSM back in IDLE.
